// File: rtl/line_window_buffer_if.sv
// Pixel stream in, 3x3 window stream out, for line_window_buffer.
// master drives pixels and out_ready; slave is the window builder.
interface line_window_buffer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;
    logic [15:0]       out_x;
    logic [15:0]       out_y;
    logic [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_sof, out_eof, out_x, out_y,
        input  win0, win1, win2, win3, win4, win5, win6, win7, win8
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_sof, out_eof, out_x, out_y,
        output win0, win1, win2, win3, win4, win5, win6, win7, win8
    );
endinterface

// File: rtl/line_window_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream using two line
// memories and a 3x3 shift register, with a single registered output stage.
module line_window_buffer #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 640
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [15:0]         width,
    input  logic [15:0]         height,
    line_window_buffer_if.slave bus,
    output logic                frame_done,
    output logic                err_size
);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [16:0] MAX_W17 = 17'(MAX_W);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  state;
    logic [15:0] x, y, w_r, h_r;

    logic [DATA_W-1:0] lm0 [MAX_W];
    logic [DATA_W-1:0] lm1 [MAX_W];

    logic [2:0][2:0][DATA_W-1:0] win_sr;   // [row][col], col 2 is newest
    logic [8:0][DATA_W-1:0]      out_win;
    logic [2:0][DATA_W-1:0]      col;      // [0] top .. [2] bottom
    logic                        out_valid_r;

    logic        acc, sof_acc, size_ok, proc, count, last_col, last_pix, emit;
    logic [15:0] cx, cy, cw, ch;
    logic [AW-1:0] xi;

    assign bus.in_ready = !out_valid_r || bus.out_ready;
    assign acc          = bus.in_valid && bus.in_ready;
    assign sof_acc      = acc && bus.in_sof;
    assign size_ok      = (width >= 16'd3) && ({1'b0, width} <= MAX_W17) &&
                          (height >= 16'd3);

    // An SOF beat is always pixel (0,0) of the size it carries.
    assign cx = sof_acc ? 16'd0 : x;
    assign cy = sof_acc ? 16'd0 : y;
    assign cw = sof_acc ? width  : w_r;
    assign ch = sof_acc ? height : h_r;

    assign proc     = sof_acc ? size_ok : (acc && state == S_ACTIVE);
    assign count    = sof_acc || (acc && state != S_IDLE);
    assign last_col = (cx == cw - 16'd1);
    assign last_pix = last_col && (cy == ch - 16'd1);
    assign emit     = proc && (cx >= 16'd2) && (cy >= 16'd2);
    assign xi       = cx[AW-1:0];

    assign col[0] = lm1[xi];
    assign col[1] = lm0[xi];
    assign col[2] = bus.in_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            w_r      <= '0;
            h_r      <= '0;
            err_size <= 1'b0;
        end else if (count) begin
            if (sof_acc) begin
                w_r      <= width;
                h_r      <= height;
                err_size <= !size_ok;
            end
            if (last_pix) begin
                state <= S_IDLE;
                x     <= '0;
                y     <= '0;
            end else begin
                if (sof_acc)
                    state <= size_ok ? S_ACTIVE : S_DISCARD;
                x <= last_col ? 16'd0 : cx + 16'd1;
                y <= last_col ? cy + 16'd1 : cy;
            end
        end
    end

    // Line memories hold no reset; stale columns never reach an output
    // because windows are only formed once x>=2 and y>=2.
    always_ff @(posedge clk) begin
        if (proc) begin
            lm1[xi] <= lm0[xi];
            lm0[xi] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_sr <= '0;
        end else if (proc) begin
            for (int r = 0; r < 3; r++) begin
                win_sr[r][0] <= win_sr[r][1];
                win_sr[r][1] <= win_sr[r][2];
                win_sr[r][2] <= col[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            bus.out_sof <= 1'b0;
            bus.out_eof <= 1'b0;
            bus.out_x   <= '0;
            bus.out_y   <= '0;
            out_win     <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= out_valid_r && bus.out_ready && bus.out_eof;
            if (emit) begin
                out_valid_r <= 1'b1;
                bus.out_x   <= cx - 16'd1;
                bus.out_y   <= cy - 16'd1;
                bus.out_sof <= (cx == 16'd2) && (cy == 16'd2);
                bus.out_eof <= last_pix;
                // Window as it will be after this pixel's column shifts in.
                out_win     <= {col[2], win_sr[2][2], win_sr[2][1],
                                col[1], win_sr[1][2], win_sr[1][1],
                                col[0], win_sr[0][2], win_sr[0][1]};
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.win0 = out_win[0];
    assign bus.win1 = out_win[1];
    assign bus.win2 = out_win[2];
    assign bus.win3 = out_win[3];
    assign bus.win4 = out_win[4];
    assign bus.win5 = out_win[5];
    assign bus.win6 = out_win[6];
    assign bus.win7 = out_win[7];
    assign bus.win8 = out_win[8];
endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: stimulus pushes expected windows,
// a forked monitor pops and compares on every output handshake.
module tb_line_window_buffer;
    localparam int DW = 8;
    localparam int MW = 16;

    typedef struct packed {
        logic [8:0][7:0] win;
        logic [15:0]     x;
        logic [15:0]     y;
        logic            sof;
        logic            eof;
    } win_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] width = '0;
    logic [15:0] height = '0;
    logic        frame_done;
    logic        err_size;

    line_window_buffer_if #(.DATA_W(DW)) bus ();

    line_window_buffer #(.DATA_W(DW), .MAX_W(MW)) dut (
        .clk(clk), .rstn(rstn), .width(width), .height(height),
        .bus(bus.slave), .frame_done(frame_done), .err_size(err_size)
    );

    win_t exp_q[$];
    int   n_chk = 0, n_fail = 0, win_cnt = 0, fd_cnt = 0, rdy_mode = 0;

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int base, input int w, input int px, input int py);
        return 8'(base + py * w + px);
    endfunction

    // Window expected when pixel (px,py) of a w x h frame is accepted.
    function automatic win_t gen_win(input int w, input int h, input int base,
                                     input int px, input int py);
        win_t r;
        for (int k = 0; k < 9; k++)
            r.win[k] = pv(base, w, px - 2 + k % 3, py - 2 + k / 3);
        r.x   = 16'(px - 1);
        r.y   = 16'(py - 1);
        r.sof = (px == 2 && py == 2);
        r.eof = (px == w - 1 && py == h - 1);
        return r;
    endfunction

    task automatic push_hand(input int cx, input int cy, input bit sof, input bit eof,
                             input int a0, input int a1, input int a2, input int a3,
                             input int a4, input int a5, input int a6, input int a7,
                             input int a8);
        win_t r;
        r.win = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        r.x = 16'(cx); r.y = 16'(cy); r.sof = sof; r.eof = eof;
        exp_q.push_back(r);
    endtask

    function automatic win_t cur_win();
        win_t r;
        r.win = {bus.win8, bus.win7, bus.win6, bus.win5, bus.win4,
                 bus.win3, bus.win2, bus.win1, bus.win0};
        r.x = bus.out_x; r.y = bus.out_y; r.sof = bus.out_sof; r.eof = bus.out_eof;
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_pix(input logic [7:0] d, input logic sof);
        int t;
        t = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_sof = sof;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin t++; @(negedge clk); end
        chk("accept", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int base,
                              input int npix, input bit push);
        int px, py;
        width = 16'(w); height = 16'(h);
        for (int i = 0; i < npix; i++) begin
            px = i % w; py = i / w;
            if (push && px >= 2 && py >= 2) exp_q.push_back(gen_win(w, h, base, px, py));
            send_pix(pv(base, w, px, py), i == 0);
            if (i == 0) begin width = 16'(w + 5); height = 16'd1; end
        end
    endtask

    task automatic drain(input string nm, input int exp_n, input int exp_fd);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 200) begin
            @(posedge clk); t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " windows"}, 128'(win_cnt), 128'(exp_n));
        chk({nm, " frame_done"}, 128'(fd_cnt), 128'(exp_fd));
        chk({nm, " leftover"}, 128'(exp_q.size()), 128'(0));
        win_cnt = 0; fd_cnt = 0; exp_q.delete();
    endtask

    task automatic monitor();
        win_t a, e, snap;
        logic stall, fd_exp;
        stall = 1'b0; fd_exp = 1'b0; snap = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall = 1'b0; fd_exp = 1'b0;
            end else begin
                a = cur_win();
                chk("frame_done", 128'(frame_done), 128'(fd_exp));
                fd_exp = 1'b0;
                if (frame_done) fd_cnt++;
                chk("in_ready", 128'(bus.in_ready), 128'(!bus.out_valid || bus.out_ready));
                if (stall) begin
                    chk("stall_valid", 128'(bus.out_valid), 128'(1));
                    chk("stall_hold", 128'(a), 128'(snap));
                end
                if (bus.out_valid && bus.out_ready) begin
                    win_cnt++;
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected window: got x=%0d y=%0d, expected none", a.x, a.y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("window", 128'(a), 128'(e));
                        fd_exp = e.eof;
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                snap = a;
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       bus.out_ready = !bus.out_ready;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    endtask

    task automatic stimulus();
        #1;
        chk("rst out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst err_size", 128'(err_size), 128'(0));
        chk("rst frame_done", 128'(frame_done), 128'(0));
        chk("rst in_ready", 128'(bus.in_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("release in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;

        // Non-SOF pixels in IDLE are swallowed.
        for (int i = 0; i < 3; i++) send_pix(8'h55, 1'b0);
        drain("idle", 0, 0);

        // 4x4, pixels 0..15.
        push_hand(1, 1, 1, 0, 0, 1, 2, 4, 5, 6, 8, 9, 10);
        push_hand(2, 1, 0, 0, 1, 2, 3, 5, 6, 7, 9, 10, 11);
        push_hand(1, 2, 0, 0, 4, 5, 6, 8, 9, 10, 12, 13, 14);
        push_hand(2, 2, 0, 1, 5, 6, 7, 9, 10, 11, 13, 14, 15);
        send_frame(4, 4, 0, 16, 0);
        drain("4x4", 4, 1);

        // 5x3 with out_ready toggling.
        rdy_mode = 1;
        send_frame(5, 3, 20, 15, 1);
        drain("5x3", 3, 1);
        rdy_mode = 0;

        // Illegal width then a legal frame.
        send_frame(2, 4, 0, 8, 0);
        drain("w2", 0, 0);
        chk("err after w2", 128'(err_size), 128'(1));
        send_frame(4, 4, 30, 16, 1);
        chk("err cleared", 128'(err_size), 128'(0));
        drain("4x4b", 4, 1);

        // Width limit.
        send_frame(MW + 1, 3, 0, 3 * (MW + 1), 0);
        drain("maxw+1", 0, 0);
        chk("err maxw+1", 128'(err_size), 128'(1));
        send_frame(MW, 3, 60, 3 * MW, 1);
        chk("err maxw", 128'(err_size), 128'(0));
        drain("maxw", MW - 2, 1);

        // SOF at pixel 7 aborts the first frame.
        send_frame(4, 4, 100, 7, 0);
        send_frame(4, 4, 0, 16, 1);
        drain("abort", 4, 1);

        // Reset with a stalled window pending.
        rdy_mode = 2;
        send_frame(4, 4, 40, 11, 1);
        chk("pre-reset valid", 128'(bus.out_valid), 128'(1));
        #1 rstn = 1'b0;
        #1;
        chk("rst mid out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst mid sof/eof", 128'({bus.out_sof, bus.out_eof}), 128'(0));
        chk("rst mid x/y", 128'({bus.out_x, bus.out_y}), 128'(0));
        chk("rst mid win", 128'(cur_win().win), 128'(0));
        chk("rst mid frame_done", 128'(frame_done), 128'(0));
        chk("rst mid err", 128'(err_size), 128'(0));
        chk("rst mid in_ready", 128'(bus.in_ready), 128'(1));
        exp_q.delete(); win_cnt = 0; fd_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        rdy_mode = 0;
        chk("release2 in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        send_frame(3, 3, 200, 9, 1);
        drain("3x3", 1, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
        fork
            monitor();
            ready_drv();
            stimulus();
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
